// File: rtl/rom_banked_if.sv
// rom_banked_if: CPU bus, bank-select and loader signals of the banked ROM store
interface rom_banked_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int NUM_BANKS  = 4
);
  localparam int BW = NUM_BANKS > 1 ? $clog2(NUM_BANKS) : 1;
  logic [ADDR_WIDTH-1:0] address;
  logic                  CS;
  logic                  RW;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] data;
  logic                  data_oe;
  logic                  write_fault;
  logic                  bank_wr;
  logic [BW-1:0]         bank_in;
  logic [BW-1:0]         bank_cur;
  logic                  load_start;
  logic [BW-1:0]         load_bank;
  logic                  load_valid;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_ready;
  logic                  load_done;
  logic                  busy;
  logic [DATA_WIDTH-1:0] checksum;
  modport master (
    output address, CS, RW, wdata, bank_wr, bank_in, load_start, load_bank, load_valid, load_data,
    input  data, data_oe, write_fault, bank_cur, load_ready, load_done, busy, checksum
  );
  modport slave (
    input  address, CS, RW, wdata, bank_wr, bank_in, load_start, load_bank, load_valid, load_data,
    output data, data_oe, write_fault, bank_cur, load_ready, load_done, busy, checksum
  );
endinterface

// File: rtl/rom_banked.sv
// rom_banked: multi-bank ROM/shadow-RAM store with streaming bank loader; ROMBANK_CHECKSUM_EN adds a loader byte checksum
module rom_banked #(
  parameter int          DATA_WIDTH    = 8,
  parameter int          ADDR_WIDTH    = 16,
  parameter int          NUM_BANKS     = 4,
  parameter int          LATENCY       = 1,
  parameter logic [15:0] WRITABLE_MASK = '0,
  parameter int          RESET_BANK    = 0,
  parameter string       FNAME         = ""
) (
  input logic         clk,
  input logic         rst_n,
  rom_banked_if.slave bus
);
  localparam int BW = NUM_BANKS > 1 ? $clog2(NUM_BANKS) : 1;
  localparam logic [BW:0] NB = (BW+1)'(NUM_BANKS);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t                state, state_d;
  logic [ADDR_WIDTH:0]   cnt, cnt_d;
  logic [BW-1:0]         lbank, lbank_d, bank_cur;
  logic [DATA_WIDTH-1:0] mem [2**(BW+ADDR_WIDTH)];
  logic [DATA_WIDTH-1:0] rdata;
  logic [LATENCY-1:0]    vq;
  logic [DATA_WIDTH-1:0] dq [LATENCY];
  logic                  busy, rd, wr, lwe, start_ok, writable, fault;
  assign busy     = state != IDLE;
  assign start_ok = state == IDLE && bus.load_start && ({1'b0, bus.load_bank} < NB);
  assign rd       = !bus.CS && bus.RW && !busy;
  assign wr       = !bus.CS && !bus.RW && !busy;
  assign lwe      = state == LOAD && bus.load_valid;
  assign writable = WRITABLE_MASK[4'(bank_cur)];
  assign fault    = wr && !writable;
  assign rdata    = mem[{bank_cur, bus.address}];
  always_ff @(posedge clk) begin
    if (lwe) mem[{lbank, cnt[ADDR_WIDTH-1:0]}] <= bus.load_data;
    else if (wr && writable) mem[{bank_cur, bus.address}] <= bus.wdata;
  end
  // the extra counter bit flags the terminal byte without wrapping
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    lbank_d = lbank;
    if (start_ok) begin
      state_d = LOAD;
      cnt_d   = '0;
      lbank_d = bus.load_bank;
    end
    if (lwe) begin
      cnt_d   = cnt + 1'b1;
      state_d = cnt_d[ADDR_WIDTH] ? DONE : LOAD;
    end
    if (state == DONE) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      lbank <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      lbank <= lbank_d;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_cur        <= BW'(RESET_BANK);
      bus.write_fault <= 1'b0;
    end else begin
      bank_cur        <= bus.bank_wr && ({1'b0, bus.bank_in} < NB) ? bus.bank_in : bank_cur;
      bus.write_fault <= fault;
    end
  end
  // the final stage only reloads on a valid read so data holds while undriven
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vq <= '0;
      for (int i = 0; i < LATENCY; i++) dq[i] <= '0;
    end else begin
      vq[0] <= rd;
      dq[0] <= (LATENCY > 1 || rd) ? rdata : dq[0];
      for (int i = 1; i < LATENCY; i++) begin
        vq[i] <= vq[i-1];
        dq[i] <= (i < LATENCY - 1 || vq[i-1]) ? dq[i-1] : dq[i];
      end
    end
  end
  assign bus.data       = dq[LATENCY-1];
  assign bus.data_oe    = vq[LATENCY-1];
  assign bus.bank_cur   = bank_cur;
  assign bus.busy       = busy;
  assign bus.load_ready = state == LOAD;
  assign bus.load_done  = state == DONE;
`ifdef ROMBANK_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) csum <= '0;
    else if (start_ok) csum <= '0;
    else if (lwe) csum <= csum + bus.load_data;
  end
  assign bus.checksum = csum;
`else
  assign bus.checksum = '0;
`endif
endmodule

// File: tb/tb_rom_banked.sv
// tb_rom_banked: directed checks of read latency, bank select, write protect, loader and checksum
module tb_rom_banked;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  logic [7:0] ck_exp;
  always #5 clk = ~clk;
  rom_banked_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .NUM_BANKS(3)) bus ();
  rom_banked #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .NUM_BANKS(3), .LATENCY(2),
    .WRITABLE_MASK(16'h0004), .RESET_BANK(0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic read_chk(input string tag, input logic [3:0] a, input logic [7:0] e);
    bus.CS = 1'b0;
    bus.RW = 1'b1;
    bus.address = a;
    tick();
    bus.CS = 1'b1;
    bus.bank_wr = 1'b0;
    chk({tag, "_oe_early"}, 32'(bus.data_oe), 0);
    tick();
    chk({tag, "_oe"}, 32'(bus.data_oe), 1);
    chk({tag, "_data"}, 32'(bus.data), 32'(e));
    tick();
    chk({tag, "_oe_off"}, 32'(bus.data_oe), 0);
    chk({tag, "_hold"}, 32'(bus.data), 32'(e));
  endtask
  task automatic set_bank(input logic [1:0] k);
    bus.bank_wr = 1'b1;
    bus.bank_in = k;
    tick();
    bus.bank_wr = 1'b0;
  endtask
  task automatic start_load(input string tag, input logic [1:0] k);
    bus.load_bank = k;
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    chk({tag, "_busy"}, 32'(bus.busy), 1);
    chk({tag, "_ready"}, 32'(bus.load_ready), 1);
  endtask
  task automatic feed(input string tag, input logic [7:0] base, input int n, input bit gaps);
    int sent = 0;
    int cyc = 0;
    int early = 0;
    while (sent < n && cyc < 400) begin
      bus.load_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.load_data = base + 8'(sent);
      tick();
      cyc++;
      if (bus.load_valid) sent++;
      if (bus.load_done && sent < n) early++;
    end
    bus.load_valid = 1'b0;
    chk({tag, "_sent"}, 32'(sent), 32'(n));
    chk({tag, "_early_done"}, 32'(early), 0);
  endtask
  task automatic finish_load(input string tag);
    chk({tag, "_done"}, 32'(bus.load_done), 1);
    chk({tag, "_ready_off"}, 32'(bus.load_ready), 0);
    tick();
    chk({tag, "_done_off"}, 32'(bus.load_done), 0);
    chk({tag, "_idle"}, 32'(bus.busy), 0);
  endtask
  initial begin
`ifdef ROMBANK_CHECKSUM_EN
    ck_exp = 8'h78;
`else
    ck_exp = 8'h00;
`endif
    bus.address = '0;
    bus.CS = 1'b1;
    bus.RW = 1'b1;
    bus.wdata = '0;
    bus.bank_wr = 1'b0;
    bus.bank_in = '0;
    bus.load_start = 1'b0;
    bus.load_bank = '0;
    bus.load_valid = 1'b0;
    bus.load_data = '0;
    repeat (2) tick();
    chk("rst_data", 32'(bus.data), 0);
    chk("rst_oe", 32'(bus.data_oe), 0);
    chk("rst_fault", 32'(bus.write_fault), 0);
    chk("rst_bank", 32'(bus.bank_cur), 0);
    chk("rst_ready", 32'(bus.load_ready), 0);
    chk("rst_done", 32'(bus.load_done), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_csum", 32'(bus.checksum), 0);
    rst_n = 1'b1;
    tick();
    start_load("ld_b0", 2'd0);
    feed("ld_b0", 8'h11, 16, 1'b0);
    finish_load("ld_b0");
    start_load("ld_b2", 2'd2);
    feed("ld_b2", 8'h33, 16, 1'b0);
    finish_load("ld_b2");
    bus.load_bank = 2'd3;
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    chk("ld_bad_bank", 32'(bus.busy), 0);
    read_chk("rd_lat", 4'h4, 8'h15);
    bus.bank_wr = 1'b1;
    bus.bank_in = 2'd2;
    read_chk("bank_race", 4'h0, 8'h11);
    chk("bank_now2", 32'(bus.bank_cur), 2);
    read_chk("bank2", 4'h0, 8'h33);
    set_bank(2'd3);
    chk("bank_bad", 32'(bus.bank_cur), 2);
    bus.CS = 1'b0;
    bus.RW = 1'b0;
    bus.address = 4'hA;
    bus.wdata = 8'h5A;
    tick();
    chk("wr_b2_fault", 32'(bus.write_fault), 0);
    read_chk("wr_b2", 4'hA, 8'h5A);
    set_bank(2'd0);
    bus.CS = 1'b0;
    bus.RW = 1'b0;
    bus.address = 4'hA;
    bus.wdata = 8'h5A;
    tick();
    bus.CS = 1'b1;
    chk("wr_b0_fault", 32'(bus.write_fault), 1);
    tick();
    chk("wr_b0_fault_off", 32'(bus.write_fault), 0);
    read_chk("wr_b0", 4'hA, 8'h1B);
    start_load("ld_b1", 2'd1);
    chk("ld_b1_csum_clr", 32'(bus.checksum), 0);
    feed("ld_b1", 8'h00, 16, 1'b1);
    finish_load("ld_b1");
    chk("ld_b1_csum", 32'(bus.checksum), 32'(ck_exp));
    set_bank(2'd1);
    read_chk("b1_a0", 4'h0, 8'h00);
    read_chk("b1_a7", 4'h7, 8'h07);
    read_chk("b1_aF", 4'hF, 8'h0F);
    set_bank(2'd2);
    start_load("ld_busy", 2'd0);
    bus.CS = 1'b0;
    bus.RW = 1'b0;
    bus.address = 4'h3;
    bus.wdata = 8'h99;
    tick();
    chk("busy_fault", 32'(bus.write_fault), 0);
    bus.RW = 1'b1;
    tick();
    bus.CS = 1'b1;
    chk("busy_oe1", 32'(bus.data_oe), 0);
    tick();
    chk("busy_oe2", 32'(bus.data_oe), 0);
    tick();
    chk("busy_oe3", 32'(bus.data_oe), 0);
    feed("ld_busy", 8'h11, 16, 1'b0);
    finish_load("ld_busy");
    read_chk("busy_wr_dropped", 4'h3, 8'h36);
    start_load("ld_rst", 2'd1);
    feed("ld_rst", 8'hC0, 5, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("midrst_busy", 32'(bus.busy), 0);
    chk("midrst_ready", 32'(bus.load_ready), 0);
    chk("midrst_bank", 32'(bus.bank_cur), 0);
    chk("midrst_csum", 32'(bus.checksum), 0);
    rst_n = 1'b1;
    tick();
    chk("midrst_idle", 32'(bus.busy), 0);
    set_bank(2'd1);
    read_chk("midrst_a0", 4'h0, 8'hC0);
    read_chk("midrst_a4", 4'h4, 8'hC4);
    read_chk("midrst_a5", 4'h5, 8'h05);
    read_chk("midrst_aF", 4'hF, 8'h0F);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
